// File: rtl/ntt_axil_if.sv
// AXI4-Lite slave bus bundle for the NTT control register block.
interface ntt_axil_if #(
  parameter int AW = 4,
  parameter int DW = 32
) ();
  logic [AW-1:0]   S_AXI_AWADDR;
  logic            S_AXI_AWVALID;
  logic            S_AXI_AWREADY;
  logic [DW-1:0]   S_AXI_WDATA;
  logic [DW/8-1:0] S_AXI_WSTRB;
  logic            S_AXI_WVALID;
  logic            S_AXI_WREADY;
  logic [1:0]      S_AXI_BRESP;
  logic            S_AXI_BVALID;
  logic            S_AXI_BREADY;
  logic [AW-1:0]   S_AXI_ARADDR;
  logic            S_AXI_ARVALID;
  logic            S_AXI_ARREADY;
  logic [DW-1:0]   S_AXI_RDATA;
  logic [1:0]      S_AXI_RRESP;
  logic            S_AXI_RVALID;
  logic            S_AXI_RREADY;

  modport slave (
    input  S_AXI_AWADDR, S_AXI_AWVALID, S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
           S_AXI_BREADY, S_AXI_ARADDR, S_AXI_ARVALID, S_AXI_RREADY,
    output S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID,
           S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
  );

  modport master (
    output S_AXI_AWADDR, S_AXI_AWVALID, S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
           S_AXI_BREADY, S_AXI_ARADDR, S_AXI_ARVALID, S_AXI_RREADY,
    input  S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID,
           S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
  );
endinterface

// File: rtl/ntt_axil_ctrl_irq.sv
// AXI4-Lite control/status registers for the NTT core: start pulse, mode,
// busy/done/err tracking, run cycle counter and level done interrupt.
module ntt_axil_ctrl_irq #(
  parameter int C_ADDR_WIDTH = 4,
  parameter int C_DATA_WIDTH = 32
) (
  input  logic       ACLK,
  input  logic       ARESET,
  ntt_axil_if.slave  s_axi,
  output logic       ntt_start,
  output logic       ntt_mode,
  input  logic       ntt_done,
  output logic       irq
);
  localparam int WW = C_ADDR_WIDTH - 2;
  localparam int SW = C_DATA_WIDTH / 8;
  localparam logic [WW-1:0] A_CTRL = WW'(0);
  localparam logic [WW-1:0] A_STAT = WW'(1);
  localparam logic [WW-1:0] A_IEN  = WW'(2);
  localparam logic [WW-1:0] A_CYC  = WW'(3);

  typedef enum logic { W_IDLE, W_RESP } w_state_e;
  typedef enum logic { R_IDLE, R_DATA } r_state_e;

  w_state_e                w_state_q, w_state_d;
  r_state_e                r_state_q, r_state_d;
  logic                    aw_got_q, aw_got_d, w_got_q, w_got_d;
  logic [C_ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
  logic [C_DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [SW-1:0]           wstrb_q, wstrb_d;
  logic                    awready_q, awready_d, wready_q, wready_d, bvalid_q, bvalid_d;
  logic                    arready_q, arready_d, rvalid_q, rvalid_d;
  logic [C_DATA_WIDTH-1:0] rdata_q, rdata_d, rd_mux;
  logic                    start_q, start_d, mode_q, mode_d, busy_q, busy_d;
  logic                    done_q, done_d, err_q, err_d, irq_en_q, irq_en_d, irq_q, irq_d;
  logic [C_DATA_WIDTH-1:0] cycles_q, cycles_d;

  logic                    aw_hs, w_hs, wr_commit;
  logic [C_ADDR_WIDTH-1:0] wr_addr;
  logic [C_DATA_WIDTH-1:0] wr_data;
  logic [SW-1:0]           wr_strb;
  logic [WW-1:0]           wr_word, rd_word;
  logic                    ctrl_wr, stat_wr, ien_wr;
  logic                    start_ok, start_err, done_set, done_err;
  logic                    unused_bits;

  assign s_axi.S_AXI_AWREADY = awready_q;
  assign s_axi.S_AXI_WREADY  = wready_q;
  assign s_axi.S_AXI_BVALID  = bvalid_q;
  assign s_axi.S_AXI_BRESP   = 2'b00;
  assign s_axi.S_AXI_ARREADY = arready_q;
  assign s_axi.S_AXI_RVALID  = rvalid_q;
  assign s_axi.S_AXI_RDATA   = rdata_q;
  assign s_axi.S_AXI_RRESP   = 2'b00;
  assign ntt_start = start_q;
  assign ntt_mode  = mode_q;
  assign irq       = irq_q;

  // A channel captured in an earlier cycle is taken from its holding flops,
  // otherwise straight from the bus in the handshake cycle.
  assign aw_hs   = awready_q & s_axi.S_AXI_AWVALID;
  assign w_hs    = wready_q & s_axi.S_AXI_WVALID;
  assign wr_addr = aw_got_q ? awaddr_q : s_axi.S_AXI_AWADDR;
  assign wr_data = w_got_q  ? wdata_q  : s_axi.S_AXI_WDATA;
  assign wr_strb = w_got_q  ? wstrb_q  : s_axi.S_AXI_WSTRB;
  assign wr_word = wr_addr[C_ADDR_WIDTH-1:2];
  assign rd_word = s_axi.S_AXI_ARADDR[C_ADDR_WIDTH-1:2];
  assign unused_bits = ^{wr_addr[1:0], wr_data[C_DATA_WIDTH-1:3], wr_strb[SW-1:1],
                         s_axi.S_AXI_ARADDR[1:0]};

  // Write channel: independent AW/W capture, commit when both held, then B.
  always_comb begin
    w_state_d = w_state_q;
    aw_got_d  = aw_got_q;
    w_got_d   = w_got_q;
    awaddr_d  = awaddr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    bvalid_d  = bvalid_q;
    wr_commit = 1'b0;
    unique case (w_state_q)
      W_IDLE: begin
        if (aw_hs) begin
          aw_got_d = 1'b1;
          awaddr_d = s_axi.S_AXI_AWADDR;
        end
        if (w_hs) begin
          w_got_d = 1'b1;
          wdata_d = s_axi.S_AXI_WDATA;
          wstrb_d = s_axi.S_AXI_WSTRB;
        end
        if ((aw_got_q | aw_hs) & (w_got_q | w_hs)) begin
          wr_commit = 1'b1;
          aw_got_d  = 1'b0;
          w_got_d   = 1'b0;
          bvalid_d  = 1'b1;
          w_state_d = W_RESP;
        end
      end
      W_RESP: begin
        if (s_axi.S_AXI_BREADY) begin
          bvalid_d  = 1'b0;
          w_state_d = W_IDLE;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
    awready_d = (w_state_d == W_IDLE) & ~aw_got_d;
    wready_d  = (w_state_d == W_IDLE) & ~w_got_d;
  end

  // Read data mux over the register map; unmapped words read as zero.
  always_comb begin
    rd_mux = '0;
    if (rd_word == A_CTRL)      rd_mux[1]   = mode_q;
    else if (rd_word == A_STAT) rd_mux[2:0] = {err_q, busy_q, done_q};
    else if (rd_word == A_IEN)  rd_mux[0]   = irq_en_q;
    else if (rd_word == A_CYC)  rd_mux      = cycles_q;
  end

  // Read channel: register the mux on AR handshake, hold until RREADY.
  always_comb begin
    r_state_d = r_state_q;
    rvalid_d  = rvalid_q;
    rdata_d   = rdata_q;
    unique case (r_state_q)
      R_IDLE: begin
        if (arready_q & s_axi.S_AXI_ARVALID) begin
          rdata_d   = rd_mux;
          rvalid_d  = 1'b1;
          r_state_d = R_DATA;
        end
      end
      R_DATA: begin
        if (s_axi.S_AXI_RREADY) begin
          rvalid_d  = 1'b0;
          r_state_d = R_IDLE;
        end
      end
      default: r_state_d = R_IDLE;
    endcase
    arready_d = (r_state_d == R_IDLE);
  end

  // Register-file and run-tracking updates; hardware sets beat W1C clears.
  assign ctrl_wr   = wr_commit & wr_strb[0] & (wr_word == A_CTRL);
  assign stat_wr   = wr_commit & wr_strb[0] & (wr_word == A_STAT);
  assign ien_wr    = wr_commit & wr_strb[0] & (wr_word == A_IEN);
  assign start_ok  = ctrl_wr & wr_data[0] & ~busy_q;
  assign start_err = ctrl_wr & wr_data[0] & busy_q;
  assign done_set  = ntt_done & busy_q;
  assign done_err  = ntt_done & ~busy_q;

  always_comb begin
    start_d  = start_ok;
    mode_d   = (ctrl_wr & ~busy_q) ? wr_data[1] : mode_q;
    irq_en_d = ien_wr ? wr_data[0] : irq_en_q;
    busy_d   = busy_q;
    if (start_ok)      busy_d = 1'b1;
    else if (done_set) busy_d = 1'b0;
    done_d = done_q;
    if ((stat_wr & wr_data[0]) | start_ok) done_d = 1'b0;
    if (done_set)                          done_d = 1'b1;
    err_d = err_q;
    if (stat_wr & wr_data[2])  err_d = 1'b0;
    if (start_err | done_err)  err_d = 1'b1;
    cycles_d = cycles_q;
    if (start_ok)
      cycles_d = '0;
    else if (busy_q & ~ntt_done & (cycles_q != '1))
      cycles_d = cycles_q + 1'b1;
    irq_d = done_q & irq_en_q;
  end

  // State registers with synchronous reset.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      w_state_q <= W_IDLE;
      r_state_q <= R_IDLE;
      aw_got_q  <= 1'b0;
      w_got_q   <= 1'b0;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      start_q   <= 1'b0;
      mode_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      irq_en_q  <= 1'b1;
      cycles_q  <= '0;
      irq_q     <= 1'b0;
    end else begin
      w_state_q <= w_state_d;
      r_state_q <= r_state_d;
      aw_got_q  <= aw_got_d;
      w_got_q   <= w_got_d;
      awaddr_q  <= awaddr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      start_q   <= start_d;
      mode_q    <= mode_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
      irq_en_q  <= irq_en_d;
      cycles_q  <= cycles_d;
      irq_q     <= irq_d;
    end
  end
endmodule

// File: tb/tb_ntt_axil_ctrl_irq.sv
// Bench for ntt_axil_ctrl_irq: behavioural register model, per-cycle compare,
// directed scenarios with literal expectations, then random traffic.
module tb_ntt_axil_ctrl_irq;
  logic ACLK = 1'b0;
  logic ARESET = 1'b1;
  logic ntt_done = 1'b0;
  logic ntt_start, ntt_mode, irq;

  ntt_axil_if #(.AW(4), .DW(32)) bus ();

  ntt_axil_ctrl_irq #(.C_ADDR_WIDTH(4), .C_DATA_WIDTH(32)) dut (
    .ACLK(ACLK), .ARESET(ARESET), .s_axi(bus.slave),
    .ntt_start(ntt_start), .ntt_mode(ntt_mode), .ntt_done(ntt_done), .irq(irq)
  );

  always #5 ACLK = ~ACLK;

  int nchk = 0, nerr = 0;
  function automatic void chk(string n, logic [31:0] act, logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", n, act, exp, $time);
    end
  endfunction

  // ---------------- behavioural model ----------------
  bit m_mode, m_busy, m_done, m_err, m_en, m_start, m_irq;
  logic [31:0] m_cyc;
  bit pa, pw;
  logic [3:0] paddr, pstrb;
  logic [31:0] pdata;
  logic [31:0] rq[$];
  int cyc = 0, start_cnt = 0, start_cyc = 0;
  bit st, sd, se, cd, ce;

  function automatic logic [31:0] model_rd(logic [3:0] a);
    case (a[3:2])
      2'd0: return {30'd0, m_mode, 1'b0};
      2'd1: return {29'd0, m_err, m_busy, m_done};
      2'd2: return {31'd0, m_en};
      default: return m_cyc;
    endcase
  endfunction

  // Model advances on every rising edge from the pre-edge bus/input values.
  initial forever begin
    @(posedge ACLK);
    cyc++;
    if (ARESET) begin
      m_mode = 0; m_busy = 0; m_done = 0; m_err = 0; m_en = 1;
      m_start = 0; m_irq = 0; m_cyc = 0; pa = 0; pw = 0;
      rq.delete();
    end else begin
      if (bus.S_AXI_ARVALID && bus.S_AXI_ARREADY) rq.push_back(model_rd(bus.S_AXI_ARADDR));
      if (bus.S_AXI_AWVALID && bus.S_AXI_AWREADY) begin pa = 1; paddr = bus.S_AXI_AWADDR; end
      if (bus.S_AXI_WVALID && bus.S_AXI_WREADY) begin
        pw = 1; pdata = bus.S_AXI_WDATA; pstrb = bus.S_AXI_WSTRB;
      end
      st = 0; sd = 0; se = 0; cd = 0; ce = 0;
      m_irq = m_done && m_en;
      if (pa && pw) begin
        pa = 0; pw = 0;
        if (pstrb[0]) begin
          case (paddr[3:2])
            2'd0: if (pdata[0]) begin
                    if (m_busy) se = 1; else st = 1;
                  end else if (!m_busy) m_mode = pdata[1];
            2'd1: begin cd = pdata[0]; ce = pdata[2]; end
            2'd2: m_en = pdata[0];
            default: ;
          endcase
        end
      end
      if (ntt_done) begin
        if (m_busy) sd = 1; else se = 1;
      end
      if (m_busy && !ntt_done && m_cyc != 32'hFFFF_FFFF) m_cyc = m_cyc + 1;
      if (st) begin
        m_mode = pdata[1]; m_busy = 1; m_cyc = 0; cd = 1;
      end else if (sd) m_busy = 0;
      if (sd) m_done = 1; else if (cd) m_done = 0;
      if (se) m_err = 1; else if (ce) m_err = 0;
      m_start = st;
    end
  end

  // Per-cycle compare of DUT outputs against the model, on the falling edge.
  initial forever begin
    @(negedge ACLK);
    chk("ntt_start", {31'd0, ntt_start}, {31'd0, m_start});
    chk("ntt_mode", {31'd0, ntt_mode}, {31'd0, m_mode});
    chk("irq", {31'd0, irq}, {31'd0, m_irq});
    if (ntt_start) begin start_cnt++; start_cyc = cyc; end
    if (bus.S_AXI_RVALID && bus.S_AXI_RREADY) begin
      if (rq.size() == 0) begin
        nchk++; nerr++;
        $display("FAIL rdata_unexpected: got 0x%0h, expected no read", bus.S_AXI_RDATA);
      end else chk("rdata", bus.S_AXI_RDATA, rq.pop_front());
    end
  end

  initial begin
    #500000;
    nerr++;
    $display("FAIL watchdog: got timeout, expected completion");
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $fatal(1, "watchdog expired");
  end

  // ---------------- bus tasks ----------------
  task automatic idle(input int n);
    repeat (n) @(posedge ACLK);
    #1;
  endtask

  task automatic pulse_done();
    @(posedge ACLK); #1 ntt_done = 1'b1;
    @(posedge ACLK); #1 ntt_done = 1'b0;
  endtask

  task automatic axi_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int ad, input int wd, input int bd);
    int t = 0, bc = 0;
    bit awd = 0, wdn = 0, bseen = 0, bdone = 0;
    while (!bdone && t < 200) begin
      @(posedge ACLK); #1;
      bus.S_AXI_AWVALID = !awd && t >= ad;
      bus.S_AXI_AWADDR  = a;
      bus.S_AXI_WVALID  = !wdn && t >= wd;
      bus.S_AXI_WDATA   = d;
      bus.S_AXI_WSTRB   = s;
      bus.S_AXI_BREADY  = bseen && bc >= bd;
      @(negedge ACLK);
      if (bus.S_AXI_AWVALID && bus.S_AXI_AWREADY) awd = 1;
      if (bus.S_AXI_WVALID && bus.S_AXI_WREADY) wdn = 1;
      if (bseen) chk("bvalid_hold", {31'd0, bus.S_AXI_BVALID}, 32'd1);
      if (bus.S_AXI_BVALID) begin
        if (bus.S_AXI_BREADY) begin
          bdone = 1;
          chk("bresp", {30'd0, bus.S_AXI_BRESP}, 32'd0);
        end else begin
          bseen = 1; bc++;
        end
      end
      t++;
    end
    @(posedge ACLK); #1;
    bus.S_AXI_AWVALID = 0; bus.S_AXI_WVALID = 0; bus.S_AXI_BREADY = 0;
    if (!bdone) chk("write_timeout", 32'd0, 32'd1);
  endtask

  task automatic axi_read(input logic [3:0] a, output logic [31:0] d);
    int t = 0;
    bit ard = 0, rdn = 0;
    d = '0;
    while (!rdn && t < 200) begin
      @(posedge ACLK); #1;
      bus.S_AXI_ARVALID = !ard;
      bus.S_AXI_ARADDR  = a;
      bus.S_AXI_RREADY  = ard;
      @(negedge ACLK);
      if (bus.S_AXI_ARVALID && bus.S_AXI_ARREADY) ard = 1;
      if (bus.S_AXI_RVALID && bus.S_AXI_RREADY) begin
        rdn = 1; d = bus.S_AXI_RDATA;
        chk("rresp", {30'd0, bus.S_AXI_RRESP}, 32'd0);
      end
      t++;
    end
    @(posedge ACLK); #1;
    bus.S_AXI_ARVALID = 0; bus.S_AXI_RREADY = 0;
    if (!rdn) chk("read_timeout", 32'd0, 32'd1);
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    axi_write(a, d, 4'hF, 0, 0, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_awready"}, {31'd0, bus.S_AXI_AWREADY}, 32'd0);
    chk({tag, "_wready"},  {31'd0, bus.S_AXI_WREADY}, 32'd0);
    chk({tag, "_arready"}, {31'd0, bus.S_AXI_ARREADY}, 32'd0);
    chk({tag, "_bvalid"},  {31'd0, bus.S_AXI_BVALID}, 32'd0);
    chk({tag, "_rvalid"},  {31'd0, bus.S_AXI_RVALID}, 32'd0);
    chk({tag, "_rdata"},   bus.S_AXI_RDATA, 32'd0);
    chk({tag, "_start"},   {31'd0, ntt_start}, 32'd0);
    chk({tag, "_mode"},    {31'd0, ntt_mode}, 32'd0);
    chk({tag, "_irq"},     {31'd0, irq}, 32'd0);
  endtask

  // ---------------- stimulus ----------------
  logic [31:0] v, v2;
  int sc;

  initial begin
    bus.S_AXI_AWVALID = 0; bus.S_AXI_AWADDR = '0; bus.S_AXI_WVALID = 0;
    bus.S_AXI_WDATA = '0; bus.S_AXI_WSTRB = '0; bus.S_AXI_BREADY = 0;
    bus.S_AXI_ARVALID = 0; bus.S_AXI_ARADDR = '0; bus.S_AXI_RREADY = 0;
    repeat (2) @(posedge ACLK);
    @(negedge ACLK);
    check_reset_outputs("reset");
    @(posedge ACLK); #1 ARESET = 1'b0;
    idle(2);

    // Reset register values.
    axi_read(4'h0, v); chk("rst_ctrl", v, 32'h0);
    axi_read(4'h4, v); chk("rst_status", v, 32'h0);
    axi_read(4'h8, v); chk("rst_irq_en", v, 32'h1);
    axi_read(4'hC, v); chk("rst_cycles", v, 32'h0);
    chk("rst_irq_lvl", {31'd0, irq}, 32'd0);

    // Basic run, 300-cycle duration, then acknowledge.
    sc = start_cnt;
    wr(4'h0, 32'h1);
    idle(1);
    chk("run1_pulses", start_cnt - sc, 32'd1);
    chk("run1_mode", {31'd0, ntt_mode}, 32'd0);
    axi_read(4'h4, v); chk("run1_busy", v, 32'h2);
    while (cyc - start_cyc < 300) idle(1);
    ntt_done = 1'b1; idle(1); ntt_done = 1'b0;
    idle(3);
    axi_read(4'h4, v); chk("run1_done", v, 32'h1);
    chk("run1_irq", {31'd0, irq}, 32'd1);
    axi_read(4'hC, v); chk("run1_cycles_300", {31'd0, v >= 299 && v <= 301}, 32'd1);
    wr(4'h4, 32'h1);
    wr(4'h4, 32'h0);
    idle(2);
    chk("ack_irq", {31'd0, irq}, 32'd0);
    axi_read(4'h4, v); chk("ack_status", v, 32'h0);

    // iNTT run and start while busy.
    sc = start_cnt;
    wr(4'h0, 32'h3);
    idle(1);
    chk("intt_pulse", start_cnt - sc, 32'd1);
    chk("intt_mode", {31'd0, ntt_mode}, 32'd1);
    wr(4'h0, 32'h1);
    idle(1);
    chk("busy_nopulse", start_cnt - sc, 32'd1);
    chk("busy_mode_kept", {31'd0, ntt_mode}, 32'd1);
    axi_read(4'h4, v); chk("busy_err_status", v, 32'h6);
    pulse_done(); idle(2);
    axi_read(4'h4, v); chk("done_err_status", v, 32'h5);
    wr(4'h4, 32'h5);
    axi_read(4'h4, v); chk("clear_both", v, 32'h0);

    // Interrupt masking.
    wr(4'h8, 32'h0);
    wr(4'h0, 32'h1);
    idle(20);
    pulse_done(); idle(3);
    axi_read(4'h4, v); chk("masked_done", v, 32'h1);
    chk("masked_irq", {31'd0, irq}, 32'd0);
    wr(4'h8, 32'h1);
    chk("unmask_irq", {31'd0, irq}, 32'd1);
    wr(4'h4, 32'h1);

    // Skewed AW/W with stalled B, concurrent CYCLES read.
    wr(4'h0, 32'h1);
    idle(4);
    fork
      axi_write(4'h8, 32'h1, 4'hF, 0, 3, 5);
      axi_read(4'hC, v2);
    join
    chk("skew_cycles_nonzero", {31'd0, v2 != 0}, 32'd1);
    pulse_done(); idle(2);
    wr(4'h4, 32'h1);

    // Hardware DONE set coincides with W1C of DONE: set wins.
    wr(4'h0, 32'h1);
    idle(5);
    fork
      axi_write(4'h4, 32'h1, 4'hF, 0, 0, 0);
      pulse_done();
    join
    axi_read(4'h4, v); chk("set_beats_clear", v, 32'h1);
    wr(4'h4, 32'h1);

    // Reset in the middle of a run, then a stray done.
    wr(4'h0, 32'h3);
    idle(10);
    ARESET = 1'b1;
    @(posedge ACLK);
    @(negedge ACLK);
    check_reset_outputs("midrst");
    @(posedge ACLK); #1 ARESET = 1'b0;
    idle(2);
    axi_read(4'h4, v); chk("midrst_status", v, 32'h0);
    axi_read(4'hC, v); chk("midrst_cycles", v, 32'h0);
    axi_read(4'h8, v); chk("midrst_irq_en", v, 32'h1);
    pulse_done(); idle(1);
    axi_read(4'h4, v); chk("stray_done_err", v, 32'h4);
    wr(4'h4, 32'h4);

    // Random traffic against the model.
    for (int i = 0; i < 60; i++) begin
      int op;
      logic [3:0] ra, rs;
      logic [31:0] rd;
      op = $urandom_range(0, 5);
      ra = 4'($urandom_range(0, 3) * 4);
      rd = 32'($urandom_range(0, 7));
      rs = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'hF;
      case (op)
        0, 1: axi_write(ra, rd, rs, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
        2: axi_read(ra, v);
        3: fork
             axi_write(ra, rd, rs, $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 4));
             axi_read(4'($urandom_range(0, 3) * 4), v2);
           join
        4: pulse_done();
        default: idle($urandom_range(1, 20));
      endcase
    end
    idle(4);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule

// File: doc/ntt_axil_ctrl_irq.md
Name: ntt_axil_ctrl_irq

Overview:
- AXI4-Lite slave control/status register file for the NTT core, sitting between the PS GP master port (base 0x43C0_0000) and the NTT datapath controller.
- Converts PS register writes into a single-cycle start pulse plus a mode level, and tracks busy/done/error.
- Drives the level-sensitive done interrupt to the PS IRQ_F2P line and exposes a cycle counter of the last run.

Parameters:
- C_ADDR_WIDTH, 4, byte address bits decoded (registers at 0x00–0x0C)
- C_DATA_WIDTH, 32, AXI-Lite data width (fixed at 32)

Ports:
- ACLK  in  1  single clock for all logic
- ARESET  in  1  synchronous, active-high reset
- S_AXI_AWADDR  in  C_ADDR_WIDTH  write address
- S_AXI_AWVALID / S_AXI_AWREADY  in/out  1  write-address handshake
- S_AXI_WDATA  in  32  write data
- S_AXI_WSTRB  in  4  byte strobes
- S_AXI_WVALID / S_AXI_WREADY  in/out  1  write-data handshake
- S_AXI_BRESP  out  2  write response
- S_AXI_BVALID / S_AXI_BREADY  out/in  1  write-response handshake
- S_AXI_ARADDR  in  C_ADDR_WIDTH  read address
- S_AXI_ARVALID / S_AXI_ARREADY  in/out  1  read-address handshake
- S_AXI_RDATA  out  32  read data
- S_AXI_RRESP  out  2  read response
- S_AXI_RVALID / S_AXI_RREADY  out/in  1  read-data handshake
- ntt_start  out  1  one-cycle start pulse to the NTT core
- ntt_mode  out  1  0 = NTT, 1 = iNTT; held stable for the whole run
- ntt_done  in  1  one-cycle completion pulse from the NTT core
- irq  out  1  level interrupt = STATUS.done & IRQ_EN.en

Behaviour:
- Register map:
  - 0x00 CTRL: bit0 START (write-1 pulses, reads 0); bit1 MODE (R/W).
  - 0x04 STATUS: bit0 DONE (W1C); bit1 BUSY (RO); bit2 ERR (W1C).
  - 0x08 IRQ_EN: bit0 (R/W, reset 1).
  - 0x0C CYCLES: RO, cycle count of the last run.
- Reset values: all AXI ready/valid = 0; BRESP = RRESP = 0; RDATA = 0; ntt_start = 0; ntt_mode = 0; irq = 0; DONE = BUSY = ERR = 0; CYCLES = 0; IRQ_EN = 1.
- Write channel FSM, states W_IDLE → W_RESP:
  - AW and W are accepted independently; each READY is high in W_IDLE until that channel's handshake, then low.
  - Once both are captured, the register update happens that cycle and the FSM enters W_RESP with BVALID = 1 the next cycle.
  - BVALID holds until BREADY, then returns to W_IDLE.
  - One outstanding write only.
- Read channel FSM, states R_IDLE → R_DATA:
  - ARREADY = 1 in R_IDLE.
  - On handshake, RDATA is registered and RVALID = 1 on the next cycle.
  - RVALID holds until RREADY.
  - Read and write channels run concurrently.
- Address decode:
  - Unmapped word address: write ignored with BRESP = OKAY; read returns 0.
  - WSTRB applies per byte; START and MODE are taken only if WSTRB[0] = 1.
- Start:
  - A CTRL write with bit0 = 1 while BUSY = 0 gives ntt_start = 1 for exactly the cycle after the write commit.
  - The same cycle sets BUSY = 1, clears DONE, and zeroes CYCLES.
  - ntt_mode is updated from bit1 in the same commit as START.
  - MODE writes while BUSY = 1 are ignored, so ntt_mode stays stable through a run.
- Start while BUSY = 1: no pulse; ERR is set.
- While BUSY: CYCLES increments by 1 per cycle and saturates at 0xFFFF_FFFF.
- ntt_done while BUSY = 1: BUSY ← 0 and DONE ← 1 in the next cycle; CYCLES freezes.
- ntt_done while BUSY = 0: ERR is set; DONE is unchanged.
- W1C writes to STATUS:
  - Writing 1 to DONE or ERR clears that bit; writing 0 has no effect.
  - The ack sequence "write 1 then write 0" leaves DONE = 0.
- Simultaneous set and clear: if a hardware set of DONE or ERR and its W1C occur in the same cycle, the set wins.
- irq: registered, asserted one cycle after DONE & IRQ_EN becomes true, and deasserted one cycle after that condition clears.
- ARESET mid-run: all state returns to reset values. A later ntt_done then sets ERR, because BUSY = 0.

Test Plan:
- Reset, then read 0x00, 0x04, 0x08, 0x0C → 0x0, 0x0, 0x1, 0x0; irq = 0.
- Write 0x00 = 0x1 → single ntt_start pulse, ntt_mode = 0, STATUS = 0x2. Pulse ntt_done 300 cycles later → STATUS = 0x1, irq = 1, CYCLES = 300 ±1. Write 0x04 = 0x1 then 0x0 → irq = 0, STATUS = 0x0.
- Write 0x00 = 0x3 → ntt_mode = 1 with pulse. Write 0x00 = 0x1 while busy → no pulse, ntt_mode stays 1, STATUS = 0x6.
- Write 0x08 = 0 and complete a run → STATUS.DONE = 1, irq stays 0. Then write 0x08 = 1 → irq = 1 next cycle.
- Issue AW 3 cycles before W, with BREADY held low for 5 cycles → BVALID stays high until BREADY. A concurrent read of 0x0C completes unaffected.
- Apply ntt_done in the same cycle as a W1C of DONE → DONE = 1. Assert ARESET mid-run → all outputs return to reset values.
